sign_narrow: RTL and testbench
==============================

# sign_narrow

Narrows a 9-bit two's-complement value to 8 bits: the inverse of the 8→9 sign-extension path in the datapath. Used where ALU or adder results (9-bit) are written back to 8-bit registers or memory. The block detects overflow, then either saturates or wraps the value. It passes results through a valid/ready pipeline stage with a skid entry, so throughput is one word per cycle under backpressure, and it keeps sticky and counted overflow status for the control unit.

## Interface
- IN_W, 9, input width (two's complement)
- OUT_W, 8, output width; must be IN_W-1
- CNT_W, 8, overflow counter width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- in_valid  input  1  datain is presented
- in_ready  output  1  block accepts datain this cycle
- datain  input  IN_W  value to narrow
- sat_en  input  1  1 = saturate on overflow, 0 = wrap (truncate); sampled with datain
- out_valid  output  1  out is valid
- out_ready  input  1  consumer accepts out
- out  output  OUT_W  narrowed value
- out_ovf  output  1  the word on out overflowed
- ovf_sticky  output  1  set on any accepted overflowing word
- ovf_count  output  CNT_W  number of accepted overflowing words, saturating
- clr  input  1  clears ovf_sticky and ovf_count

## Operation
- Accept happens when in_valid && in_ready. Emit happens when out_valid && out_ready.
- Overflow: ovf = datain[IN_W-1] != datain[IN_W-2].
- Result value:
  - No ovf: datain[OUT_W-1:0].
  - ovf and sat_en=1: datain[IN_W-1]=0 gives 0x7F; datain[IN_W-1]=1 gives 0x80.
  - ovf and sat_en=0: datain[OUT_W-1:0] (wrapped).
- Storage is two entries, each holding {value, ovf}:
  - Main register drives out and out_ovf.
  - Skid register holds a word that arrived while main was full and stalled.
- States are EMPTY (no entries), ONE (main valid), FULL (main and skid valid).
  - EMPTY→ONE on accept.
  - ONE→ONE on accept with emit, or on neither.
  - ONE→FULL on accept without emit.
  - ONE→EMPTY on emit without accept.
  - FULL→ONE on emit: skid moves to main. No accept is possible in FULL.
- in_ready = 1 when state ≠ FULL and reset = 0. It is a registered state decode, with no combinational path from out_ready.
- Ordering is strict FIFO. No word is dropped or duplicated.
- Status updates on each accept:
  - If ovf: ovf_sticky←1 and ovf_count←ovf_count+1, holding at 2^CNT_W-1.
  - clr alone: sticky←0, count←0.
  - clr in the same cycle as an overflowing accept: sticky←1, count←1. The new event is counted after the clear.
  - Status counts accepts, not emits.

## Timing
- Latency: an accepted word appears on out the next cycle (out_valid=1) if main was empty or emitting that cycle.
- Throughput: 1 word/cycle with out_ready held high.
- out and out_ovf are held stable while out_valid && !out_ready.
- Reset, synchronous: on the next edge state=EMPTY, out_valid=0, out=0, out_ovf=0, ovf_sticky=0, ovf_count=0.
  - in_ready=0 while reset is high, and 1 the cycle after reset deasserts.
  - Reset mid-stream discards both entries. No emit occurs on the reset edge.
- sat_en changing between words affects only words accepted after the change.

## Structure
- Shared definitions package/header: IN_W, OUT_W, CNT_W defaults; SAT_POS=8'h7F, SAT_NEG=8'h80; state encodings EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- Sub-module narrow_core: purely combinational {datain, sat_en} → {value, ovf}. It is reusable by the ALU writeback path.
- Top level sign_narrow: state machine, main/skid registers, status counter.

## Test plan
- Reset then stream 0x07F, 0x180, 0x0FF, 0x100 with sat_en=1 and out_ready=1. Required out: 0x7F/ovf0, 0x80/ovf0, 0x7F/ovf1, 0x80/ovf1, each 1 cycle after its accept. ovf_count=2, ovf_sticky=1.
- Same stream with sat_en=0. Required out: 0x7F, 0x80, 0xFF/ovf1, 0x00/ovf1.
- Backpressure: out_ready=0 while sending 0x005, 0x006. Required: state FULL, in_ready=0 the next cycle, out held at 0x05. Raise out_ready: 0x05 then 0x06 emerge in order, in_ready returns to 1.
- Counter saturation: send 260 overflowing words (0x0C0). Required: ovf_count=255. Then clr together with an overflowing accept gives count=1, sticky=1. clr alone gives 0, 0.
- Reset mid-operation while FULL. Required: the next cycle has out_valid=0, ovf_count=0, in_ready=0 during reset; the first post-reset word 0x012 gives out=0x12.
- Random valid/ready toggling with 1000 words against a reference model. Required: no loss, duplication, or reorder; out stable under stall.

Source files
------------

// File: rtl/sign_narrow_pkg.sv
// Shared definitions for the 9-to-8 bit narrowing path: default widths,
// saturation constants and pipeline occupancy states.
package sign_narrow_pkg;

    localparam int unsigned IN_W  = 9;
    localparam int unsigned OUT_W = IN_W - 1;
    localparam int unsigned CNT_W = 8;

    localparam logic [7:0] SAT_POS = 8'h7F;
    localparam logic [7:0] SAT_NEG = 8'h80;

    // Number of words held in the output stage
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

endpackage

// File: rtl/sign_narrow_core.sv
// Combinational narrowing of a two's-complement value by one bit, with
// overflow detection and optional saturation. Shared with the ALU writeback.
module narrow_core #(
    parameter int unsigned IN_W  = 9,
    parameter int unsigned OUT_W = IN_W - 1
) (
    input  logic [IN_W-1:0]  datain,
    input  logic             sat_en,
    output logic [OUT_W-1:0] value,
    output logic             ovf
);

    localparam logic [OUT_W-1:0] SatPos = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SatNeg = {1'b1, {(OUT_W-1){1'b0}}};

    // Overflow when the dropped sign bit disagrees with the new sign bit
    always_comb begin
        ovf   = datain[IN_W-1] ^ datain[IN_W-2];
        value = datain[OUT_W-1:0];
        if (ovf && sat_en) begin
            value = datain[IN_W-1] ? SatNeg : SatPos;
        end
    end

endmodule

// File: rtl/sign_narrow.sv
// Narrowing stage with a two-entry valid/ready buffer (main + skid) and
// sticky / counted overflow status for the control unit.
module sign_narrow #(
    parameter int unsigned IN_W  = sign_narrow_pkg::IN_W,
    parameter int unsigned OUT_W = IN_W - 1,
    parameter int unsigned CNT_W = sign_narrow_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  datain,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr
);

    import sign_narrow_pkg::*;

    state_e           state_q;
    logic [OUT_W-1:0] main_val_q;
    logic             main_ovf_q;
    logic [OUT_W-1:0] skid_val_q;
    logic             skid_ovf_q;
    logic             sticky_q;
    logic [CNT_W-1:0] count_q;

    logic [OUT_W-1:0] new_val;
    logic             new_ovf;
    logic             accept;
    logic             emit;

    narrow_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .datain (datain),
        .sat_en (sat_en),
        .value  (new_val),
        .ovf    (new_ovf)
    );

    // Ready is a pure state decode so out_ready never reaches in_ready
    assign in_ready   = (state_q != StFull) && !reset;
    assign out_valid  = (state_q != StEmpty);
    assign out        = main_val_q;
    assign out_ovf    = main_ovf_q;
    assign ovf_sticky = sticky_q;
    assign ovf_count  = count_q;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    // Occupancy FSM moving words through main and skid entries in order
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StEmpty;
            main_val_q <= '0;
            main_ovf_q <= 1'b0;
            skid_val_q <= '0;
            skid_ovf_q <= 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_val_q <= new_val;
                        main_ovf_q <= new_ovf;
                        state_q    <= StOne;
                    end
                end
                StOne: begin
                    if (accept && emit) begin
                        main_val_q <= new_val;
                        main_ovf_q <= new_ovf;
                    end else if (accept) begin
                        // Main is stalled, park the new word behind it
                        skid_val_q <= new_val;
                        skid_ovf_q <= new_ovf;
                        state_q    <= StFull;
                    end else if (emit) begin
                        state_q    <= StEmpty;
                    end
                end
                StFull: begin
                    if (emit) begin
                        main_val_q <= skid_val_q;
                        main_ovf_q <= skid_ovf_q;
                        state_q    <= StOne;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    // Overflow status counts accepted words; a coincident event survives clr
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else if (clr) begin
            sticky_q <= accept && new_ovf;
            count_q  <= (accept && new_ovf) ? CNT_W'(1) : '0;
        end else if (accept && new_ovf) begin
            sticky_q <= 1'b1;
            if (count_q != {CNT_W{1'b1}}) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sign_narrow.sv
// Self-checking bench for sign_narrow: directed steps plus a random
// valid/ready run, checked against a scoreboard queue and a status model.
module tb_sign_narrow;

    import sign_narrow_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] datain = '0;
    logic       sat_en = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out;
    logic       out_ovf;
    logic       ovf_sticky;
    logic [7:0] ovf_count;
    logic       clr = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [8:0] sb_q[$];   // {ovf, value} in acceptance order
    int         mdl_count = 0;
    logic       mdl_sticky = 1'b0;
    logic       mon_en = 1'b0;
    logic       rand_mode = 1'b0;

    sign_narrow dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .datain     (datain),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count),
        .clr        (clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: range check on the signed value
    function automatic logic [8:0] ref_narrow(input logic [8:0] d, input logic s);
        int v;
        v = $signed(d);
        if (v > 127)  return s ? {1'b1, SAT_POS} : {1'b1, d[7:0]};
        if (v < -128) return s ? {1'b1, SAT_NEG} : {1'b1, d[7:0]};
        return {1'b0, d[7:0]};
    endfunction

    // Monitor: compare outputs with the model, then advance the model
    always @(negedge clk) begin
        if (mon_en) begin
            if (reset) begin
                check("in_ready_in_reset", in_ready, 0);
                sb_q.delete();
                mdl_count  = 0;
                mdl_sticky = 1'b0;
            end else begin
                logic [8:0] exp_w;
                logic [8:0] got;
                check("in_ready", in_ready, sb_q.size() < 2);
                check("out_valid", out_valid, sb_q.size() > 0);
                check("ovf_count", ovf_count, mdl_count);
                check("ovf_sticky", ovf_sticky, mdl_sticky);
                if (out_valid && sb_q.size() > 0) begin
                    exp_w = sb_q[0];
                    check("out_word", {out_ovf, out}, exp_w);
                end
                if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
                if (in_valid && in_ready) begin
                    got = ref_narrow(datain, sat_en);
                    sb_q.push_back(got);
                    if (clr) begin
                        mdl_count  = got[8] ? 1 : 0;
                        mdl_sticky = got[8];
                    end else if (got[8]) begin
                        mdl_sticky = 1'b1;
                        if (mdl_count < 255) mdl_count++;
                    end
                end else if (clr) begin
                    mdl_count  = 0;
                    mdl_sticky = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present one word and hold it until accepted; returns 1 time unit after the accept edge
    task automatic send(input logic [8:0] d, input logic s);
        int n;
        n = 0;
        in_valid = 1'b1;
        datain   = d;
        sat_en   = s;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] stream[4];
        logic [8:0] exp_sat[4];
        logic [8:0] exp_wrap[4];
        int n;
        stream   = '{9'h07F, 9'h180, 9'h0FF, 9'h100};
        exp_sat  = '{9'h07F, 9'h080, 9'h17F, 9'h180};
        exp_wrap = '{9'h07F, 9'h080, 9'h1FF, 9'h100};

        // Reset
        repeat (3) tick();
        mon_en = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_count", ovf_count, 0);
        check("rst_sticky", ovf_sticky, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
        tick();

        // Saturating stream; each word on out one cycle after its accept
        for (int i = 0; i < 4; i++) begin
            send(stream[i], 1'b1);
            check("sat_valid", out_valid, 1);
            check("sat_word", {out_ovf, out}, exp_sat[i]);
        end
        check("sat_count", ovf_count, 2);
        check("sat_sticky", ovf_sticky, 1);

        // Wrapping stream
        for (int i = 0; i < 4; i++) begin
            send(stream[i], 1'b0);
            check("wrap_word", {out_ovf, out}, exp_wrap[i]);
        end
        check("wrap_count", ovf_count, 4);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_count", ovf_count, 0);
        check("clr_sticky", ovf_sticky, 0);

        // Backpressure fills main and skid
        out_ready = 1'b0;
        send(9'h005, 1'b1);
        send(9'h006, 1'b1);
        check("bp_in_ready", in_ready, 0);
        check("bp_out", out, 8'h05);
        tick();
        check("bp_hold", out, 8'h05);
        out_ready = 1'b1;
        tick();
        check("bp_second", out, 8'h06);
        check("bp_ready_back", in_ready, 1);
        tick();
        check("bp_drained", out_valid, 0);

        // Counter saturation
        for (int i = 0; i < 260; i++) send(9'h0C0, 1'b1);
        check("cnt_sat", ovf_count, 255);
        check("cnt_sticky", ovf_sticky, 1);
        clr = 1'b1;
        send(9'h0C0, 1'b1);
        clr = 1'b0;
        check("clr_ovf_count", ovf_count, 1);
        check("clr_ovf_sticky", ovf_sticky, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_only_count", ovf_count, 0);
        check("clr_only_sticky", ovf_sticky, 0);

        // Reset while full
        out_ready = 1'b0;
        send(9'h100, 1'b1);
        send(9'h0C0, 1'b1);
        check("full_before_rst", in_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", in_ready, 0);
        tick();
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_count", ovf_count, 0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        send(9'h012, 1'b0);
        check("post_rst_word", {out_ovf, out}, 9'h012);
        tick();

        // Random valid/ready traffic against the scoreboard
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            clr = ($urandom_range(0, 31) == 0);
            send(9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
            clr = 1'b0;
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        @(negedge clk);
        check("drain_empty", sb_q.size(), 0);
        check("drain_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
